// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, memory request channel, in-order response FIFO.
// Feeds control_unit; supports redirect with stale-response drop, and halt.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_vld,
    input  logic        imem_req_rdy,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_vld,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        isns_vld,
    input  logic        ins_rdy,
    output logic        halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [2:0] LAST    = 3'(DEPTH - 1);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] rsp_pc;
    logic [3:0]  live_cnt;
    logic [3:0]  drop_cnt;
    logic [3:0]  buf_cnt;
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [31:0] fifo_ins [8];
    logic [31:0] fifo_pc  [8];

    logic        req_fire;
    logic        pop;
    logic        rsp_ok;
    logic        push;
    logic [3:0]  used;
    logic [31:0] redir_pc;

    function automatic logic [2:0] nxt(input logic [2:0] p);
        return (p == LAST) ? 3'd0 : p + 3'd1;
    endfunction

    // Outstanding plus buffered words never exceed DEPTH, so pushes never overflow.
    assign used         = live_cnt + drop_cnt + buf_cnt;
    assign imem_req_vld = ~reset & (state == FETCH) & (used < DEPTH_C);
    assign imem_addr    = pc;
    assign req_fire     = imem_req_vld & imem_req_rdy;

    assign isns_vld = (buf_cnt != 4'd0);
    assign pop      = isns_vld & ins_rdy;
    assign ins      = isns_vld ? fifo_ins[rd_ptr] : NOP_INS;
    assign ins_pc   = isns_vld ? fifo_pc[rd_ptr] : 32'd0;
    assign halted   = (state == HALT);

    // A response with nothing outstanding is ignored outright.
    assign rsp_ok   = imem_rsp_vld & ((live_cnt != 4'd0) | (drop_cnt != 4'd0));
    assign push     = rsp_ok & (drop_cnt == 4'd0);
    assign redir_pc = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (push && !reset && !redirect_vld) begin
            fifo_ins[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]  <= rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            live_cnt <= 4'd0;
            drop_cnt <= 4'd0;
            buf_cnt  <= 4'd0;
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
        end else if (redirect_vld) begin
            // Everything in flight, including a request firing now, is dropped.
            state    <= FETCH;
            pc       <= redir_pc;
            rsp_pc   <= redir_pc;
            live_cnt <= 4'd0;
            drop_cnt <= drop_cnt + live_cnt + {3'd0, req_fire}
                        - {3'd0, rsp_ok};
            buf_cnt  <= 4'd0;
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
        end else begin
            if (state == FETCH && halt_req) begin
                state <= HALT;
            end
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            live_cnt <= live_cnt + {3'd0, req_fire} - {3'd0, push};
            if (rsp_ok && drop_cnt != 4'd0) begin
                drop_cnt <= drop_cnt - 4'd1;
            end
            if (push) begin
                wr_ptr <= nxt(wr_ptr);
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            buf_cnt <= buf_cnt + {3'd0, push} - {3'd0, pop};
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scripted cycles, 1-cycle memory model,
// queue scoreboard for request addresses and delivered instructions.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req_vld;
    logic        imem_req_rdy;
    logic [31:0] imem_addr;
    logic        imem_rsp_vld;
    logic [31:0] imem_rsp_data;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        isns_vld;
    logic        ins_rdy;
    logic        halted;

    logic        mem_hold;
    logic [31:0] mem_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_ins_q[$];
    int          total;
    int          bad;

    instr_fetch_unit #(
        .RESET_PC(RPC),
        .DEPTH   (2),
        .NOP_INS (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req_vld (imem_req_vld),
        .imem_req_rdy (imem_req_rdy),
        .imem_addr    (imem_addr),
        .imem_rsp_vld (imem_rsp_vld),
        .imem_rsp_data(imem_rsp_data),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .halt_req     (halt_req),
        .ins          (ins),
        .ins_pc       (ins_pc),
        .isns_vld     (isns_vld),
        .ins_rdy      (ins_rdy),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory: answers each accepted request in order, no earlier than next cycle.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            mem_q.delete();
            imem_rsp_vld  = 1'b0;
            imem_rsp_data = 32'd0;
        end else begin
            if (!mem_hold && mem_q.size() > 0) begin
                imem_rsp_vld  = 1'b1;
                imem_rsp_data = word(mem_q.pop_front());
            end else begin
                imem_rsp_vld  = 1'b0;
                imem_rsp_data = 32'd0;
            end
            if (imem_req_vld && imem_req_rdy) mem_q.push_back(imem_addr);
        end
    end

    // Monitor: pops the scoreboard whenever a request fires or a word is taken.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (imem_req_vld && imem_req_rdy) begin
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexp: got %h want none", imem_addr);
                end else begin
                    chk("req_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (isns_vld && ins_rdy && !redirect_vld) begin
                if (exp_ins_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ins_unexp: got %h want none", ins_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_ins_q.pop_front();
                    chk("ins_pc", ins_pc, e);
                    chk("ins", ins, word(e));
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic rdy, input logic irdy,
                       input logic hold, input logic hreq,
                       input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset        = r;
        imem_req_rdy = rdy;
        ins_rdy      = irdy;
        mem_hold     = hold;
        halt_req     = hreq;
        redirect_vld = rv;
        redirect_pc  = rpc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic exp_push(input logic [31:0] a[$], input logic [31:0] p[$]);
        foreach (a[i]) exp_addr_q.push_back(a[i]);
        foreach (p[i]) exp_ins_q.push_back(p[i]);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_vld"}, 32'(imem_req_vld), 32'd0);
        chk({tag, "_addr"}, imem_addr, RPC);
        chk({tag, "_isns_vld"}, 32'(isns_vld), 32'd0);
        chk({tag, "_ins"}, ins, NOP);
        chk({tag, "_ins_pc"}, ins_pc, 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        imem_req_rdy  = 1'b1;
        ins_rdy       = 1'b1;
        mem_hold      = 1'b0;
        halt_req      = 1'b0;
        redirect_vld  = 1'b0;
        redirect_pc   = 32'd0;
        imem_rsp_vld  = 1'b0;
        imem_rsp_data = 32'd0;

        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        #3 chk_reset("rst");

        // Sequential fetch through the address wrap
        exp_push('{RPC, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8},
                 '{RPC, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8});
        run(1);
        #3 chk("first_req", 32'(imem_req_vld), 32'd1);
        run(1);
        #3 chk("vld_c2", 32'(isns_vld), 32'd0);
        run(1);
        #3 chk("vld_c3", 32'(isns_vld), 32'd1);
        run(4);

        // Consumer backpressure fills the FIFO and stops requests
        exp_push('{32'hC, 32'h10}, '{32'hC, 32'h10});
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        #3;
        chk("bp_req_vld", 32'(imem_req_vld), 32'd0);
        chk("bp_isns_vld", 32'(isns_vld), 32'd1);
        chk("bp_head_pc", ins_pc, 32'h8);
        chk("bp_head", ins, word(32'h8));
        cyc(0, 1, 0, 0, 0, 0, 0);
        #3 chk("bp_req_vld2", 32'(imem_req_vld), 32'd0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        #3 chk("bp_pop_req", 32'(imem_req_vld), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Memory stall holds the request
        exp_push('{32'h14}, '{32'h14});
        cyc(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            #3;
            chk("stall_vld", 32'(imem_req_vld), 32'd1);
            chk("stall_addr", imem_addr, 32'h14);
        end
        run(2);

        // Redirect with two requests in flight
        exp_push('{32'h18, 32'h1C, 32'h100, 32'h104}, '{32'h100, 32'h104});
        cyc(0, 1, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 1, 32'h103);
        cyc(0, 1, 1, 0, 0, 0, 0);
        #3;
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_flush", 32'(isns_vld), 32'd0);
        chk("redir_req_vld", 32'(imem_req_vld), 32'd0);
        run(3);

        // Halt, drain, resume by redirect (redirect beats halt_req)
        exp_push('{32'h108, 32'h40, 32'h44, 32'h48}, '{32'h108, 32'h40, 32'h44});
        cyc(0, 1, 1, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        #3 chk("halted", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 0, 0);
            #3;
            chk("halt_stay", 32'(halted), 32'd1);
            chk("halt_no_req", 32'(imem_req_vld), 32'd0);
        end
        cyc(0, 1, 1, 0, 1, 1, 32'h40);
        cyc(0, 1, 1, 0, 0, 0, 0);
        #3 chk("resumed", 32'(halted), 32'd0);
        run(3);

        // Reset with a request outstanding
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        #3;
        chk_reset("midrst");
        chk("sb_addr_left", 32'(exp_addr_q.size()), 32'd0);
        chk("sb_ins_left", 32'(exp_ins_q.size()), 32'd0);
        exp_push('{RPC, 32'hFFFF_FFFC, 32'h0}, '{RPC, 32'hFFFF_FFFC, 32'h0});
        run(3);
        cyc(0, 1, 1, 0, 1, 0, 0);
        run(4);

        chk("end_addr_left", 32'(exp_addr_q.size()), 32'd0);
        chk("end_ins_left", 32'(exp_ins_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
